// File: rtl/wave_column_scan_if.sv
// Column stream between the wave column scanner and the wave pixel renderer.
//   col_valid  : col_x/col_height hold a column
//   col_ready  : downstream accepts the column this cycle
//   col_x      : column number
//   col_height : wave surface height at that column
// master = scanner (producer), slave = renderer (consumer).
interface wave_column_scan_if;
    logic        col_valid;
    logic        col_ready;
    logic [10:0] col_x;
    logic [9:0]  col_height;

    modport master (
        output col_valid,
        output col_x,
        output col_height,
        input  col_ready
    );

    modport slave (
        input  col_valid,
        input  col_x,
        input  col_height,
        output col_ready
    );
endinterface

// File: rtl/wave_column_scan.sv
// Per-frame column scanner for the wave display.
// On frame_start it latches the tone id, fetches that tone's phase step from the ROM,
// then walks H_ACTIVE columns, looking up |sine| at each column's phase and streaming
// registered (x, height) pairs downstream with a valid/ready handshake. A per-frame
// phase offset (advanced by scroll_step after each frame) makes the wave scroll.
//
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   frame_start    : one-cycle pulse, starts a scan (ignored unless idle)
//   freq_id_in     : tone id for the next scan (31 = flat)
//   scroll_step    : per-frame phase advance in ROM index units
//   rom_index      : ROM sine index (acc[17:8], 0..1023)
//   rom_freq_id    : ROM frequency id, latched at frame start
//   rom_value      : ROM |sine| value at rom_index
//   rom_freq       : ROM phase step for rom_freq_id
//   col            : column stream (master side)
//   busy           : scanner not idle
//   done           : one-cycle pulse after the last column is accepted
module wave_column_scan #(
    parameter int unsigned H_ACTIVE  = 1024,
    parameter int unsigned AMP_SHIFT = 0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      frame_start,
    input  logic [4:0]                freq_id_in,
    input  logic [10:0]               scroll_step,
    output logic [10:0]               rom_index,
    output logic [4:0]                rom_freq_id,
    input  logic [9:0]                rom_value,
    input  logic [10:0]               rom_freq,
    wave_column_scan_if.master        col,
    output logic                      busy,
    output logic                      done
);

    localparam logic [10:0] LastX = 11'(H_ACTIVE - 1);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRun,
        StDrain
    } state_e;

    state_e      state_q;
    logic [17:0] phase_q;
    logic [17:0] acc_q;
    logic [10:0] x_q;
    logic [10:0] freq_step_q;

    // Upper ten accumulator bits address one full sine period of 1024 entries.
    assign rom_index = {1'b0, acc_q[17:8]};
    assign busy      = (state_q != StIdle);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            phase_q        <= '0;
            acc_q          <= '0;
            x_q            <= '0;
            freq_step_q    <= '0;
            rom_freq_id    <= '0;
            col.col_valid  <= 1'b0;
            col.col_x      <= '0;
            col.col_height <= '0;
            done           <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (frame_start) begin
                        rom_freq_id <= freq_id_in;
                        state_q     <= StLoad;
                    end
                end
                StLoad: begin
                    // ROM is combinational on rom_freq_id, already latched last cycle.
                    freq_step_q <= rom_freq;
                    acc_q       <= phase_q;
                    x_q         <= '0;
                    state_q     <= StRun;
                end
                StRun: begin
                    // Issue when the output register is empty or being drained this cycle.
                    if (!col.col_valid || col.col_ready) begin
                        col.col_x      <= x_q;
                        col.col_height <= rom_value >> AMP_SHIFT;
                        col.col_valid  <= 1'b1;
                        acc_q          <= acc_q + 18'(freq_step_q);
                        x_q            <= x_q + 11'd1;
                        if (x_q == LastX) begin
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (col.col_valid && col.col_ready) begin
                        col.col_valid <= 1'b0;
                        done          <= 1'b1;
                        phase_q       <= phase_q + 18'({scroll_step, 8'b0});
                        state_q       <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
